axis_rr_packet_arbiter: RTL



---
 rtl/axis_arb_pkg.sv | 19 +
 rtl/axis_rr_picker.sv | 44 ++++
 rtl/axis_rr_packet_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the round-robin AXI-Stream packet arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   idx_width() : width of a port index for a given port count ($clog2(n),
//                 never less than one bit)
// -----------------------------------------------------------------------------
package axis_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// -----------------------------------------------------------------------------
// axis_rr_picker
// Combinational rotate-priority encoder. Scans req starting one above 'last',
// wrapping modulo N_PORTS, and returns the first requesting index.
//   req  in  N_PORTS  request vector
//   last in  idx      most recently granted port (highest priority goes to last+1)
//   pick out idx      chosen port (0 when nothing requests)
//   any  out 1        at least one request present
// -----------------------------------------------------------------------------
module axis_rr_picker
   import axis_arb_pkg::*;
#(
   parameter int N_PORTS = 2
) (
   input  logic [N_PORTS-1:0]                req,
   input  logic [idx_width(N_PORTS)-1:0]     last,
   output logic [idx_width(N_PORTS)-1:0]     pick,
   output logic                              any
);

   localparam int IDX_W = idx_width(N_PORTS);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Offsets 1..N_PORTS visit every port once; offset N_PORTS comes back to
   // 'last' itself, so a lone requester is always re-granted.
   always_comb begin
      pick     = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 1; off <= N_PORTS; off++) begin
         cand = int'(last) + off;
         if (cand >= N_PORTS) cand = cand - N_PORTS;
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            pick = cand_idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_packet_arbiter
// Round-robin packet arbiter sharing one downstream AXI-Stream video channel
// among N_PORTS line sources. A grant is held from the first beat up to and
// including the accepted tlast beat, so packets never interleave.
//
// Handshake: a beat moves on a rising clk edge where valid and ready are both
// high. m_valid/m_data/m_tlast/m_tuser are a combinational mux of the granted
// port; s_ready of the granted port is m_ready, all other s_ready are 0.
// m_valid never depends on m_ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   s_data/s_valid/s_tlast/s_tuser/s_ready   per-port upstream channel
//   m_data/m_valid/m_tlast/m_tuser/m_ready   downstream channel
//   grant_id             currently or last granted port
//   busy                 high while LOCKED (mirrors FSM state)
//   pkt_cnt              completed packets per port, CNT_WIDTH each
//                        (present only when ARB_PKT_CNT_EN is defined)
//
// Build option: `define ARB_PKT_CNT_EN adds the per-port packet counters.
// -----------------------------------------------------------------------------
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int N_PORTS   = 2,
   parameter int D_WIDTH   = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_PORTS*D_WIDTH-1:0]     s_data,
   input  logic [N_PORTS-1:0]             s_valid,
   input  logic [N_PORTS-1:0]             s_tlast,
   input  logic [N_PORTS-1:0]             s_tuser,
   output logic [N_PORTS-1:0]             s_ready,
   output logic [D_WIDTH-1:0]             m_data,
   output logic                           m_valid,
   output logic                           m_tlast,
   output logic                           m_tuser,
   input  logic                           m_ready,
   output logic [idx_width(N_PORTS)-1:0]  grant_id,
   output logic                           busy
`ifdef ARB_PKT_CNT_EN
   ,
   output logic [N_PORTS*CNT_WIDTH-1:0]   pkt_cnt
`endif
);

   localparam int IDX_W = idx_width(N_PORTS);

   arb_state_t       state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] pick;
   logic             any;
   logic             g_valid;
   logic             tlast_acc;

   axis_rr_picker #(
      .N_PORTS (N_PORTS)
   ) u_picker (
      .req  (s_valid),
      .last (last_grant),
      .pick (pick),
      .any  (any)
   );

   // Output mux from the granted port. Data fields are don't-care while
   // m_valid is low, so they follow grant_id even in IDLE.
   always_comb begin
      m_data  = '0;
      m_tlast = 1'b0;
      m_tuser = 1'b0;
      g_valid = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant_id == IDX_W'(i)) begin
            m_data  = s_data[i*D_WIDTH +: D_WIDTH];
            m_tlast = s_tlast[i];
            m_tuser = s_tuser[i];
            g_valid = s_valid[i];
         end
      end
   end

   // busy is cleared by the asynchronous reset, so valid/ready drop at once.
   assign m_valid = busy & g_valid;

   always_comb begin
      s_ready = '0;
      if (busy) s_ready[grant_id] = m_ready;
   end

   assign tlast_acc = m_valid & m_ready & m_tlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= IDX_W'(N_PORTS - 1);
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  grant_id   <= pick;
                  last_grant <= pick;
                  busy       <= 1'b1;
                  state      <= LOCKED;
               end
            end
            LOCKED: begin
               // Valid gaps from the granted port simply hold the lock.
               if (tlast_acc) begin
                  last_grant <= grant_id;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PKT_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q [N_PORTS];

   // Counters wrap naturally at 2^CNT_WIDTH and clear only on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
      end else if (tlast_acc) begin
         cnt_q[grant_id] <= cnt_q[grant_id] + CNT_WIDTH'(1);
      end
   end

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cnt_out
      assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gi];
   end
`endif

endmodule
